// File: rtl/mips_status_pkg.sv
// mips_status_pkg
//   Shared definitions for the core status stream and its checker.
//   - status_e    : 2-bit status code reported by core (o_status)
//   - STATUS_W    : width of status_e
//   - chk_state_e : checker FSM state
//   - is_terminal : true for codes that end a program (OVERFLOW, END)
package mips_status_pkg;

  localparam int unsigned STATUS_W = 2;

  typedef enum logic [STATUS_W-1:0] {
    R_TYPE   = 2'd0,
    I_TYPE   = 2'd1,
    OVERFLOW = 2'd2,
    END      = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  function automatic logic is_terminal(input logic [STATUS_W-1:0] s);
    return (s == OVERFLOW) || (s == END);
  endfunction

endpackage

// File: rtl/mips_status_checker_watchdog.sv
// status_watchdog
//   Counts enabled cycles from 0 after a clear. o_expired is registered and
//   is high during the enabled cycle in which the count equals TIMEOUT-1.
//   Once expired, the count holds until the next clear.
// Ports:
//   i_clk     : clock
//   i_rst_n   : asynchronous active-low reset
//   i_clear   : restart the count at 0 (next cycle is count 0)
//   i_enable  : count this cycle
//   o_expired : watchdog has reached TIMEOUT-1
module status_watchdog #(
  parameter int unsigned TIMEOUT = 120000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  // o_expired is computed from the next count value so that it is
  // aligned with the cycle holding count == TIMEOUT-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      o_expired <= 1'b0;
    end else if (i_clear) begin
      cnt       <= '0;
      o_expired <= (TIMEOUT <= 1);
    end else if (i_enable && !o_expired) begin
      cnt       <= cnt + CW'(1);
      o_expired <= ((cnt + CW'(1)) == CW'(TIMEOUT - 1));
    end
  end

endmodule

// File: rtl/mips_status_checker.sv
// mips_status_checker
//   Receives the core status stream and compares each accepted status with a
//   golden status memory (combinational read at o_gold_addr). Counts
//   instructions and mismatches, detects program end and memory overrun.
//   Optional watchdog: define MIPS_STATUS_CHK_WATCHDOG_EN to force a stop
//   TIMEOUT cycles after entering RUN; otherwise o_timeout is tied to 0 and
//   TIMEOUT is unused.
// Ports:
//   i_clk, i_rst_n    : clock, asynchronous active-low reset
//   i_start           : arm/restart (ignored while running)
//   i_status(_valid)  : status stream from core
//   o_gold_addr       : golden memory index; i_gold_status is its entry
//   o_inst_cnt        : accepted statuses (wrapping)
//   o_err_cnt         : mismatches (saturating)
//   o_first_err_idx   : index of the first mismatch
//   o_done, o_pass    : check finished; pass valid while done
//   o_timeout         : watchdog expired
module mips_status_checker
  import mips_status_pkg::*;
#(
  parameter int unsigned GOLD_DEPTH = 1024,
  parameter int unsigned TIMEOUT    = 120000,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned AW        = $clog2(GOLD_DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [STATUS_W-1:0] i_status,
  input  logic                i_status_valid,
  output logic [AW-1:0]       o_gold_addr,
  input  logic [STATUS_W-1:0] i_gold_status,
  output logic [CNT_W-1:0]    o_inst_cnt,
  output logic [CNT_W-1:0]    o_err_cnt,
  output logic [AW-1:0]       o_first_err_idx,
  output logic                o_done,
  output logic                o_pass,
  output logic                o_timeout
);

  chk_state_e state;

  logic             accept;
  logic             mismatch;
  logic             overrun;
  logic             valid_end;
  logic [1:0]       err_add;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_next;
  logic [CNT_W-1:0] err_final;
  logic             wd_expired;
  logic             wd_stop;

  assign accept   = (state == RUN) && i_status_valid;
  assign mismatch = (i_status != i_gold_status);
  assign overrun  = (o_gold_addr == AW'(GOLD_DEPTH - 1));

  // An overrun on a non-terminal golden entry costs one error on top of
  // any mismatch on that same sample.
  assign err_add  = {1'b0, mismatch} + {1'b0, overrun && !is_terminal(i_gold_status)};
  assign err_sum  = {1'b0, o_err_cnt} + (CNT_W + 1)'(err_add);
  assign err_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  assign err_final = accept ? err_next : o_err_cnt;

  assign valid_end = accept &&
                     (is_terminal(i_status) || is_terminal(i_gold_status) || overrun);

  // A valid that ends the run on the expiry cycle wins over the watchdog.
  assign wd_stop = wd_expired && !valid_end;

`ifdef MIPS_STATUS_CHK_WATCHDOG_EN
  status_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (i_start && (state != RUN)),
    .i_enable  (state == RUN),
    .o_expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
  assign o_timeout  = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      o_gold_addr     <= '0;
      o_inst_cnt      <= '0;
      o_err_cnt       <= '0;
      o_first_err_idx <= '0;
      o_done          <= 1'b0;
      o_pass          <= 1'b0;
`ifdef MIPS_STATUS_CHK_WATCHDOG_EN
      o_timeout       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state           <= RUN;
            o_gold_addr     <= '0;
            o_inst_cnt      <= '0;
            o_err_cnt       <= '0;
            o_first_err_idx <= '0;
            o_done          <= 1'b0;
            o_pass          <= 1'b0;
`ifdef MIPS_STATUS_CHK_WATCHDOG_EN
            o_timeout       <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            o_inst_cnt  <= o_inst_cnt + CNT_W'(1);
            o_gold_addr <= o_gold_addr + AW'(1);
            o_err_cnt   <= err_next;
            if ((o_err_cnt == '0) && (err_add != 2'd0))
              o_first_err_idx <= o_gold_addr;
          end
          if (valid_end || wd_expired) begin
            state  <= DONE;
            o_done <= 1'b1;
            o_pass <= (err_final == '0) && !wd_stop;
`ifdef MIPS_STATUS_CHK_WATCHDOG_EN
            o_timeout <= wd_stop;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_status_checker.sv
module tb_mips_status_checker;
  import mips_status_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned CW    = 16;
  localparam int unsigned TO    = 100;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic [1:0]    i_status;
  logic          i_status_valid;
  logic [AW-1:0] o_gold_addr;
  logic [1:0]    i_gold_status;
  logic [CW-1:0] o_inst_cnt;
  logic [CW-1:0] o_err_cnt;
  logic [AW-1:0] o_first_err_idx;
  logic          o_done;
  logic          o_pass;
  logic          o_timeout;

  logic [1:0] gold_mem [DEPTH];

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  assign i_gold_status = gold_mem[o_gold_addr];

  always #5 i_clk = ~i_clk;

  mips_status_checker #(
    .GOLD_DEPTH (DEPTH),
    .TIMEOUT    (TO),
    .CNT_W      (CW)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_start         (i_start),
    .i_status        (i_status),
    .i_status_valid  (i_status_valid),
    .o_gold_addr     (o_gold_addr),
    .i_gold_status   (i_gold_status),
    .o_inst_cnt      (o_inst_cnt),
    .o_err_cnt       (o_err_cnt),
    .o_first_err_idx (o_first_err_idx),
    .o_done          (o_done),
    .o_pass          (o_pass),
    .o_timeout       (o_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [1:0] s);
    i_status       = s;
    i_status_valid = 1'b1;
    tick();
    i_status_valid = 1'b0;
  endtask

  task automatic fill_gold(input logic [1:0] s);
    for (int i = 0; i < int'(DEPTH); i++) gold_mem[i] = s;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got no finish, expected finish before 100000");
    $fatal(1, "time limit");
  end

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_status_valid = 1'b0; i_status = 2'd0;
    fill_gold(R_TYPE);
    repeat (2) tick();

    // Reset state
    check("rst.done", o_done, 0);
    check("rst.pass", o_pass, 0);
    check("rst.timeout", o_timeout, 0);
    check("rst.inst", o_inst_cnt, 0);
    check("rst.err", o_err_cnt, 0);
    check("rst.addr", o_gold_addr, 0);
    check("rst.first", o_first_err_idx, 0);

    // Valids in IDLE are ignored
    i_rst_n = 1'b1;
    tick();
    send(END);
    check("idle.inst", o_inst_cnt, 0);
    check("idle.done", o_done, 0);

    // Clean run, back-to-back
    gold_mem[0] = R_TYPE; gold_mem[1] = I_TYPE; gold_mem[2] = R_TYPE;
    gold_mem[3] = I_TYPE; gold_mem[4] = END;
    start_pulse();
    send(R_TYPE); send(I_TYPE); send(R_TYPE); send(I_TYPE);
    check("clean.done_pre", o_done, 0);
    check("clean.addr_pre", o_gold_addr, 4);
    send(END);
    check("clean.done", o_done, 1);
    check("clean.pass", o_pass, 1);
    check("clean.inst", o_inst_cnt, 5);
    check("clean.err", o_err_cnt, 0);
    check("clean.timeout", o_timeout, 0);

    // Restart from DONE clears everything
    start_pulse();
    check("restart.done", o_done, 0);
    check("restart.pass", o_pass, 0);
    check("restart.inst", o_inst_cnt, 0);
    check("restart.addr", o_gold_addr, 0);

    // Single mismatch at index 2
    send(R_TYPE); send(I_TYPE); send(I_TYPE); send(I_TYPE); send(END);
    check("mis.done", o_done, 1);
    check("mis.err", o_err_cnt, 1);
    check("mis.first", o_first_err_idx, 2);
    check("mis.pass", o_pass, 0);
    check("mis.inst", o_inst_cnt, 5);
    send(R_TYPE);
    check("done_ignores_valid.inst", o_inst_cnt, 5);

    // Overflow terminal with gaps; i_start in RUN ignored
    fill_gold(R_TYPE);
    gold_mem[1] = I_TYPE; gold_mem[2] = I_TYPE; gold_mem[3] = OVERFLOW;
    start_pulse();
    send(R_TYPE); repeat (3) tick();
    send(I_TYPE);
    i_start = 1'b1; tick(); i_start = 1'b0; tick(); tick();
    check("ovf.start_ignored_inst", o_inst_cnt, 2);
    check("ovf.start_ignored_addr", o_gold_addr, 2);
    send(I_TYPE); repeat (3) tick();
    check("ovf.done_pre", o_done, 0);
    send(OVERFLOW);
    check("ovf.done", o_done, 1);
    check("ovf.pass", o_pass, 1);
    check("ovf.inst", o_inst_cnt, 4);

    // Early gold end at index 1
    fill_gold(R_TYPE);
    gold_mem[1] = END;
    start_pulse();
    send(R_TYPE); send(I_TYPE);
    check("gend.done", o_done, 1);
    check("gend.err", o_err_cnt, 1);
    check("gend.first", o_first_err_idx, 1);
    check("gend.pass", o_pass, 0);
    check("gend.inst", o_inst_cnt, 2);

    // Core END against non-terminal gold
    fill_gold(R_TYPE);
    start_pulse();
    send(R_TYPE); send(END);
    check("cend.done", o_done, 1);
    check("cend.err", o_err_cnt, 1);
    check("cend.first", o_first_err_idx, 1);

    // Memory overrun: all-matching, non-terminal gold
    fill_gold(R_TYPE);
    start_pulse();
    for (int i = 0; i < 7; i++) send(R_TYPE);
    check("ovr.done_pre", o_done, 0);
    check("ovr.err_pre", o_err_cnt, 0);
    send(R_TYPE);
    check("ovr.done", o_done, 1);
    check("ovr.err", o_err_cnt, 1);
    check("ovr.first", o_first_err_idx, 7);
    check("ovr.inst", o_inst_cnt, 8);
    check("ovr.pass", o_pass, 0);

    // Reset mid-run
    fill_gold(R_TYPE);
    start_pulse();
    send(R_TYPE); send(R_TYPE); send(I_TYPE);
    check("mrst.inst_pre", o_inst_cnt, 3);
    #2 i_rst_n = 1'b0;
    #1;
    check("mrst.inst", o_inst_cnt, 0);
    check("mrst.err", o_err_cnt, 0);
    check("mrst.addr", o_gold_addr, 0);
    check("mrst.first", o_first_err_idx, 0);
    check("mrst.done", o_done, 0);
    tick(); tick();
    i_rst_n = 1'b1;
    send(R_TYPE); send(R_TYPE);
    check("mrst.post_inst", o_inst_cnt, 0);
    check("mrst.post_addr", o_gold_addr, 0);
    gold_mem[0] = END;
    start_pulse();
    send(END);
    check("mrst.rerun_done", o_done, 1);
    check("mrst.rerun_pass", o_pass, 1);
    check("mrst.rerun_inst", o_inst_cnt, 1);

    // Watchdog: start, no valids
    start_pulse();
    repeat (TO - 1) tick();
    check("wd.done_pre", o_done, 0);
`ifdef MIPS_STATUS_CHK_WATCHDOG_EN
    tick();
    check("wd.done", o_done, 1);
    check("wd.timeout", o_timeout, 1);
    check("wd.pass", o_pass, 0);
`else
    repeat (1000 - (TO - 1)) tick();
    check("nowd.done", o_done, 0);
    check("nowd.timeout", o_timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
